// File: rtl/fft_pkg.sv
// fft_pkg: constants and types shared by the FFT back-end blocks
// (peak detector, magnitude unit, weight block).
//   ADDR_W - FFT RAM address width (1024 bins)
//   SAMP_W - width of each real/imag component of an FFT word
//   MAG_W  - width of an unsigned |X|^2 value
//   cplx_t - one FFT RAM word, real part in the upper half
//   pbd_state_t - peak_bin_detect controller states
package fft_pkg;

  localparam int ADDR_W = 10;
  localparam int SAMP_W = 14;
  localparam int MAG_W  = 28;

  typedef struct packed {
    logic signed [SAMP_W-1:0] re;
    logic signed [SAMP_W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    COMPLETE
  } pbd_state_t;

endpackage

// File: rtl/cmagsq.sv
// cmagsq: registered complex magnitude squared, mag = re^2 + im^2.
// One clock of latency. Shared by the peak detector and the weight
// block's power path.
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   din   - complex input sample (signed re/im)
//   mag   - unsigned |din|^2, registered
module cmagsq
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  cplx_t            din,
  output logic [MAG_W-1:0] mag
);

  logic signed [MAG_W-1:0] re_x;
  logic signed [MAG_W-1:0] im_x;
  logic signed [MAG_W-1:0] re_sq;
  logic signed [MAG_W-1:0] im_sq;

  // Widen before squaring: (-8192)^2 + (-8192)^2 = 2^27 is the largest
  // possible sum, which still fits in MAG_W bits.
  assign re_x  = {{(MAG_W-SAMP_W){din.re[SAMP_W-1]}}, din.re};
  assign im_x  = {{(MAG_W-SAMP_W){din.im[SAMP_W-1]}}, din.im};
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag <= '0;
    end else begin
      mag <= $unsigned(re_sq + im_sq);
    end
  end

endmodule

// File: rtl/peak_bin_detect.sv
// peak_bin_detect: after each FFT frame, scans channel-1 FFT RAM over
// [BIN_LO, BIN_HI] and reports the bin with the largest |X|^2. While the
// result is held it parks the RAM address at that bin for the weight block.
//   clk        - system clock
//   KEY        - KEY[0] asynchronous active-low reset, KEY[3:1] unused
//   fftdone    - pulse: new FFT frame available
//   wbdone     - pulse: weight block has consumed the result
//   ramq1      - channel-1 FFT word, RD_LAT cycles after rdaddr1
//   rdaddr1    - channel-1 FFT RAM read address
//   maxbin     - bin of peak power (meaningful while detectdone=1)
//   maxmag     - |X|^2 at maxbin
//   detectdone - level: result valid until wbdone
//   quiet      - pulse: scan ended with peak below THRESH
module peak_bin_detect
  import fft_pkg::*;
#(
  parameter int               ADDR_W = 10,
  parameter int               BIN_LO = 1,
  parameter int               BIN_HI = 511,
  parameter int               RD_LAT = 2,
  parameter logic [MAG_W-1:0] THRESH = '0
) (
  input  logic              clk,
  input  logic [3:0]        KEY,
  input  logic              fftdone,
  input  logic              wbdone,
  input  logic [MAG_W-1:0]  ramq1,
  output logic [ADDR_W-1:0] rdaddr1,
  output logic [ADDR_W-1:0] maxbin,
  output logic [MAG_W-1:0]  maxmag,
  output logic              detectdone,
  output logic              quiet
);

  // Drain covers the RAM latency, the magnitude register and the final
  // compare, so the decision sees the last bin's contribution.
  localparam int DRAIN_W = $clog2(RD_LAT + 2) + 1;

  logic rst_n;
  logic key_unused;
  assign rst_n      = KEY[0];
  assign key_unused = &{1'b0, KEY[3:1]};

  pbd_state_t          state, state_next;
  logic [ADDR_W-1:0]   rdaddr, rdaddr_next;
  logic [DRAIN_W-1:0]  drain_cnt, drain_next;
  logic                clr_best, publish, quiet_next, dd_next;

  // Address tags travel beside the RAM reads so each magnitude knows its bin.
  logic [ADDR_W-1:0]   tag_pipe [RD_LAT];
  logic [RD_LAT-1:0]   vld_pipe;
  logic [ADDR_W-1:0]   mag_tag;
  logic                mag_vld;
  logic [MAG_W-1:0]    mag;

  logic [MAG_W-1:0]    best_mag;
  logic [ADDR_W-1:0]   best_bin;

  cmagsq u_cmagsq (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (cplx_t'(ramq1)),
    .mag   (mag)
  );

  always_comb begin
    state_next  = state;
    rdaddr_next = rdaddr;
    drain_next  = drain_cnt;
    clr_best    = 1'b0;
    publish     = 1'b0;
    quiet_next  = 1'b0;
    dd_next     = detectdone;
    case (state)
      IDLE: begin
        rdaddr_next = ADDR_W'(BIN_LO);
        if (fftdone) begin
          state_next = SCAN;
          clr_best   = 1'b1;
        end
      end
      SCAN: begin
        if (rdaddr == ADDR_W'(BIN_HI)) begin
          state_next = DRAIN;
          drain_next = '0;
        end else begin
          rdaddr_next = rdaddr + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_W'(RD_LAT + 1)) begin
          if (best_mag >= THRESH) begin
            publish     = 1'b1;
            dd_next     = 1'b1;
            rdaddr_next = best_bin;
            state_next  = COMPLETE;
          end else begin
            quiet_next  = 1'b1;
            rdaddr_next = ADDR_W'(BIN_LO);
            state_next  = IDLE;
          end
        end else begin
          drain_next = drain_cnt + DRAIN_W'(1);
        end
      end
      COMPLETE: begin
        // fftdone alone is dropped: the weight block owns the result.
        if (wbdone) begin
          dd_next     = 1'b0;
          rdaddr_next = ADDR_W'(BIN_LO);
          if (fftdone) begin
            state_next = SCAN;
            clr_best   = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rdaddr     <= ADDR_W'(BIN_LO);
      drain_cnt  <= '0;
      detectdone <= 1'b0;
      quiet      <= 1'b0;
      maxbin     <= '0;
      maxmag     <= '0;
      best_mag   <= '0;
      best_bin   <= '0;
      vld_pipe   <= '0;
      mag_tag    <= '0;
      mag_vld    <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      state      <= state_next;
      rdaddr     <= rdaddr_next;
      drain_cnt  <= drain_next;
      detectdone <= dd_next;
      quiet      <= quiet_next;

      tag_pipe[0] <= rdaddr;
      vld_pipe[0] <= (state == SCAN);
      for (int i = 1; i < RD_LAT; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
        vld_pipe[i] <= vld_pipe[i-1];
      end
      // cmagsq adds one register; keep the tag aligned with it.
      mag_tag <= tag_pipe[RD_LAT-1];
      mag_vld <= vld_pipe[RD_LAT-1];

      // Strict compare: on a tie the earlier (lower) bin is kept.
      if (clr_best) begin
        best_mag <= '0;
        best_bin <= ADDR_W'(BIN_LO);
      end else if (mag_vld && (mag > best_mag)) begin
        best_mag <= mag;
        best_bin <= mag_tag;
      end

      if (publish) begin
        maxbin <= best_bin;
        maxmag <= best_mag;
      end
    end
  end

  assign rdaddr1 = rdaddr;

endmodule

// File: tb/tb_peak_bin_detect.sv
module tb_peak_bin_detect;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  key;
  logic        fft_a, wb_a, fft_b, wb_b;
  logic [27:0] q_a, q_b, pa1, pb1;
  logic [9:0]  addr_a, addr_b, maxbin_a, maxbin_b;
  logic [27:0] mag_a, mag_b;
  logic        dd_a, dd_b, quiet_a, quiet_b;

  logic [27:0] mem [1024];

  // Two-cycle read-latency RAM model, one read port per DUT.
  always @(posedge clk) begin
    pa1 <= mem[addr_a];
    q_a <= pa1;
    pb1 <= mem[addr_b];
    q_b <= pb1;
  end

  peak_bin_detect dut_a (
    .clk(clk), .KEY(key), .fftdone(fft_a), .wbdone(wb_a), .ramq1(q_a),
    .rdaddr1(addr_a), .maxbin(maxbin_a), .maxmag(mag_a),
    .detectdone(dd_a), .quiet(quiet_a)
  );

  peak_bin_detect #(.THRESH(28'd1000)) dut_b (
    .clk(clk), .KEY(key), .fftdone(fft_b), .wbdone(wb_b), .ramq1(q_b),
    .rdaddr1(addr_b), .maxbin(maxbin_b), .maxmag(mag_b),
    .detectdone(dd_b), .quiet(quiet_b)
  );

  typedef struct {
    bit quiet;
    int bin;
    int mag;
    int start;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int qcnt_b = 0;
  localparam int LAT = 515;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [27:0] cw(input int re, input int im);
    logic [13:0] r, i;
    r = 14'(re);
    i = 14'(im);
    return {r, i};
  endfunction

  task automatic fill(input logic [27:0] w);
    for (int i = 0; i < 1024; i++) mem[i] = w;
  endtask

  task automatic start_a(input int bin, input int mag, input bit wb, input bit push);
    @(negedge clk);
    if (push) qa.push_back('{1'b0, bin, mag, cyc + 1});
    fft_a = 1'b1;
    wb_a  = wb;
    @(negedge clk);
    fft_a = 1'b0;
    wb_a  = 1'b0;
  endtask

  task automatic pulse_a(input bit f, input bit w);
    @(negedge clk);
    fft_a = f;
    wb_a  = w;
    @(negedge clk);
    fft_a = 1'b0;
    wb_a  = 1'b0;
  endtask

  task automatic wait_a();
    int t;
    t = 0;
    while (qa.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (qa.size() != 0) begin
      chk("timeout_a", qa.size(), 0);
      qa.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_b();
    int t;
    t = 0;
    while (qb.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (qb.size() != 0) begin
      chk("timeout_b", qb.size(), 0);
      qb.delete();
    end
    @(negedge clk);
  endtask

  // Monitor for DUT A: every rising detectdone or quiet pulse is a result.
  bit   prev_dd_a = 1'b0;
  exp_t ea;
  always @(negedge clk) begin
    if (dd_a && !prev_dd_a) begin
      $display("A detect: cyc=%0d bin=%0d mag=%0d addr=%0d", cyc, maxbin_a, mag_a, addr_a);
      if (qa.size() == 0) chk("unexpected_detect_a", 1, 0);
      else begin
        ea = qa.pop_front();
        chk("kind_a", 0, ea.quiet);
        chk("maxbin_a", maxbin_a, ea.bin);
        chk("maxmag_a", mag_a, ea.mag);
        chk("rdaddr_a", addr_a, ea.bin);
        chk("latency_a", cyc - ea.start, LAT);
      end
    end
    if (quiet_a) begin
      $display("A quiet: cyc=%0d", cyc);
      chk("unexpected_quiet_a", 1, 0);
    end
    prev_dd_a <= dd_a;
  end

  // Monitor for DUT B (threshold instance).
  bit   prev_dd_b = 1'b0;
  exp_t eb;
  always @(negedge clk) begin
    if (dd_b && !prev_dd_b) begin
      $display("B detect: cyc=%0d bin=%0d mag=%0d", cyc, maxbin_b, mag_b);
      if (qb.size() == 0) chk("unexpected_detect_b", 1, 0);
      else begin
        eb = qb.pop_front();
        chk("kind_b", 0, eb.quiet);
      end
    end
    if (quiet_b) begin
      qcnt_b <= qcnt_b + 1;
      $display("B quiet: cyc=%0d", cyc);
      if (qb.size() == 0) chk("unexpected_quiet_b", 1, 0);
      else begin
        eb = qb.pop_front();
        chk("kind_b", 1, eb.quiet);
        chk("latency_b", cyc - eb.start, LAT);
      end
    end
    prev_dd_b <= dd_b;
  end

  initial begin
    key   = 4'hF;
    fft_a = 1'b0; wb_a = 1'b0; fft_b = 1'b0; wb_b = 1'b0;
    fill(28'd0);
    #1 key[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdaddr", addr_a, 1);
    chk("rst_maxbin", maxbin_a, 0);
    chk("rst_maxmag", mag_a, 0);
    chk("rst_detectdone", dd_a, 0);
    chk("rst_quiet", quiet_a, 0);
    key[0] = 1'b1;
    repeat (2) @(negedge clk);

    // Single tone at bin 37: 100^2 + 50^2 = 12500, background 3^2+4^2 = 25.
    fill(cw(3, 4));
    mem[37] = cw(100, -50);
    start_a(37, 12500, 1'b0, 1'b1);
    wait_a();

    // fftdone alone in COMPLETE is dropped.
    pulse_a(1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("fft_ignored_dd", dd_a, 1);
    chk("fft_ignored_addr", addr_a, 37);
    // wbdone releases the result on the next cycle.
    pulse_a(1'b0, 1'b1);
    chk("wb_dd_low", dd_a, 0);
    @(negedge clk);
    chk("idle_addr", addr_a, 1);
    chk("hold_maxbin", maxbin_a, 37);

    // Tie of full-scale negatives: 2*8192^2 = 134217728, lower bin wins.
    fill(28'd0);
    mem[10]  = cw(-8192, -8192);
    mem[200] = cw(-8192, -8192);
    start_a(10, 134217728, 1'b0, 1'b1);
    wait_a();

    // Range edges: DC excluded, bin 511 = 20^2 = 400. Restart via wb+fft.
    fill(28'd0);
    mem[0]   = cw(8000, 0);
    mem[511] = cw(20, 0);
    start_a(511, 400, 1'b1, 1'b1);
    chk("wbfft_dd_low", dd_a, 0);
    chk("wbfft_addr", addr_a, 1);
    wait_a();
    pulse_a(1'b0, 1'b1);

    // Peak only at bin 512 is outside the range: all others tie at 1.
    fill(cw(1, 0));
    mem[512] = cw(500, 0);
    start_a(1, 1, 1'b0, 1'b1);
    wait_a();
    pulse_a(1'b0, 1'b1);

    // Threshold instance: every bin 10^2+10^2 = 200 < 1000 -> quiet.
    fill(cw(10, 10));
    @(negedge clk);
    qb.push_back('{1'b1, 0, 0, cyc + 1});
    fft_b = 1'b1;
    @(negedge clk);
    fft_b = 1'b0;
    wait_b();
    repeat (3) @(negedge clk);
    chk("quiet_count_b", qcnt_b, 1);
    chk("quiet_dd_b", dd_b, 0);
    chk("quiet_idle_addr_b", addr_b, 1);

    // Reset in the middle of a scan acts immediately.
    fill(cw(3, 4));
    mem[37] = cw(100, -50);
    start_a(0, 0, 1'b0, 1'b0);
    repeat (200) @(negedge clk);
    #2 key[0] = 1'b0;
    #1;
    chk("midrst_rdaddr", addr_a, 1);
    chk("midrst_maxbin", maxbin_a, 0);
    chk("midrst_maxmag", mag_a, 0);
    chk("midrst_dd", dd_a, 0);
    chk("midrst_quiet", quiet_a, 0);
    repeat (2) @(negedge clk);
    key[0] = 1'b1;
    @(negedge clk);
    start_a(37, 12500, 1'b0, 1'b1);
    wait_a();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
